// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// funct3 encodings, fault cause codes and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Illegal funct3 wins over misalignment when both apply.
  function automatic cause_e access_check(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic legal;
    if (we) legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else    legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
    if (!legal) return CAUSE_ILLEGAL;
    if ((funct3[1:0] == 2'b01) && off[0]) return CAUSE_MISALIGN;
    if ((funct3[1:0] == 2'b10) && (off != 2'b00)) return CAUSE_MISALIGN;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational.
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_wstrb_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  // Store strobes and lane-replicated write data by access size.
  always_comb begin
    st_wstrb_o = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      2'b00: begin
        st_wstrb_o = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_wstrb_o = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select with sign or zero extension.
  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data_o = {24'h000000, ld_byte};
      F3_LHU:  ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: request/grant/valid bus master
// with legality checks, bus timeout and registered load data return.
module load_store_unit import lsu_pkg::*; #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_data_mem,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Counter only needs to hold 0..TIMEOUT-1; the abort fires on the last value.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    off_q, off_d;
  logic          fault_q, fault_d;
  cause_e        cause_q, cause_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic          bwe_q, bwe_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;

  cause_e        issue_cause;
  logic [3:0]    st_wstrb;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_data;

  lsu_align u_align (
    .st_size_i   (i_funct3[1:0]),
    .st_off_i    (i_addr[1:0]),
    .st_data_i   (i_wdata),
    .st_wstrb_o  (st_wstrb),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (funct3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata),
    .ld_data_o   (ld_data)
  );

  assign issue_cause = access_check(i_we, i_funct3, i_addr[1:0]);

  // Next-state, counter and output-register updates.
  // A response in the final allowed cycle completes rather than timing out.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    fault_d  = fault_q;
    cause_d  = cause_q;
    data_d   = data_q;
    addr_d   = addr_q;
    bwe_d    = bwe_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          we_d     = i_we;
          funct3_d = i_funct3;
          off_d    = i_addr[1:0];
          if (issue_cause != CAUSE_NONE) begin
            fault_d = 1'b1;
            cause_d = issue_cause;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            addr_d  = {i_addr[31:2], 2'b00};
            bwe_d   = i_we;
            wstrb_d = i_we ? st_wstrb : '0;
            wdata_d = i_we ? st_wdata : '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid && ((state_q == S_WAIT) || mem_gnt)) begin
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
          if (!we_q) data_d = ld_data;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_DONE;
        end else if ((state_q == S_REQ) && mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      data_q   <= '0;
      addr_q   <= '0;
      bwe_q    <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      bwe_q    <= bwe_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_req       = (state_q == S_REQ);
  assign o_stall       = (state_q == S_REQ) || (state_q == S_WAIT) ||
                         ((state_q == S_IDLE) && i_valid);
  assign o_done        = (state_q == S_DONE);
  assign o_fault       = (state_q == S_DONE) && fault_q;
  assign o_fault_cause = cause_q;
  assign o_data_mem    = data_q;
  assign mem_we        = bwe_q;
  assign mem_addr      = addr_q;
  assign mem_wstrb     = wstrb_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage that sits directly downstream of the `Datapath` block's ALU output. It consumes the effective address (`o_ALU`) and store data (`o_regfile_rreg2`), and drives a request/grant/valid data-memory bus with byte-lane strobes. It returns aligned, sign- or zero-extended load data to the datapath's `o_data_mem` input. It holds `o_stall` high until the access completes, so the core freezes PC and register writeback during the access.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles allowed in REQ+WAIT before the access aborts with a bus-timeout fault.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  memory instruction present; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  instruction[14:12].
- `i_addr`  in  32  effective address (ALU result).
- `i_wdata`  in  32  store data (rs2).
- `o_data_mem`  out  32  extended load data, held until the next load completes.
- `o_stall`  out  1  access in progress; core must not advance.
- `o_done`  out  1  one-cycle completion pulse.
- `o_fault`  out  1  one-cycle pulse coincident with `o_done` when the access failed.
- `o_fault_cause`  out  2  1 = misaligned, 2 = illegal funct3, 3 = bus timeout; held until the next completion.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  32  word address; bits [1:0] are always 0.
- `mem_wstrb`  out  4  byte-lane write strobes; 0 on loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  response (load data or store acknowledge).
- `mem_rdata`  in  32  load word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, `i_valid` = 1, access legal:
  - latch `i_we`, `i_funct3` and `i_addr[1:0]`;
  - drive bus outputs (`mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`) from registers;
  - go to REQ.
- IDLE, `i_valid` = 1, access illegal: go to DONE with the fault recorded. No bus request is issued.
  - Illegal funct3 for loads: 011, 110, 111.
  - Illegal funct3 for stores: 011 through 111.
  - Misaligned: half-word with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - When both apply, illegal funct3 takes priority over misaligned.
- REQ:
  - `mem_req` = 1 and bus outputs stay stable until `mem_gnt`.
  - On `mem_gnt` go to WAIT.
  - On `mem_gnt` and `mem_rvalid` in the same cycle, complete immediately and go to DONE.
- WAIT: on `mem_rvalid`, go to DONE. For loads, capture the extended data into `o_data_mem` in that cycle.
- DONE:
  - `o_done` = 1 and `o_stall` = 0;
  - `o_fault` = 1 when a fault was recorded;
  - go to IDLE unconditionally.
- Timeout: a counter clears on entering REQ and increments every cycle in REQ or WAIT. When it reaches `TIMEOUT`:
  - drop `mem_req`;
  - set `o_fault_cause` = 3;
  - go to DONE and leave `o_data_mem` unchanged.
- `mem_rvalid` or `mem_gnt` arriving in IDLE or DONE is ignored.
- Lane steering uses `off = addr[1:0]`:
  - SB: `wstrb = 0001 << off`, `wdata` = byte replicated ×4.
  - SH: `wstrb = 0011 << off`, `wdata` = half replicated ×2.
  - SW: `wstrb = 1111`.
- Load extraction:
  - LB/LBU take byte `rdata[8*off +: 8]`; LH/LHU take half `rdata[16*off[1] +: 16]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- A store, or any faulted access, leaves `o_data_mem` unchanged.

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (`o_data_mem`, `o_fault_cause` and all `mem_*` outputs included).
- `o_stall` is combinational from state:
  - 1 in REQ and WAIT;
  - 1 in IDLE when `i_valid` = 1;
  - 0 in DONE and in idle IDLE.
- Minimum latency, with `mem_gnt` and `mem_rvalid` both high in the first REQ cycle: issue in cycle 0, REQ in cycle 1, DONE in cycle 2.
- Fault from IDLE: DONE in cycle 1.
- Back-to-back accesses always have one IDLE cycle between DONE and the next REQ.
- `rst` asserted mid-access: the next edge returns to IDLE with `mem_req` = 0. The outstanding bus response is then ignored.

## Structure
- Package `lsu_pkg` holds:
  - the state enum;
  - funct3 constants LB/LH/LW/LBU/LHU and SB/SH/SW;
  - fault cause codes: NONE = 0, MISALIGN = 1, ILLEGAL = 2, TIMEOUT = 3.
- One combinational sub-module, `lsu_align`, handles strobe/wdata generation and load extraction/extension.
- The FSM, timeout counter and output registers live in `load_store_unit`.

## Test plan
- LB at address 0x103, `mem_rdata` = 0x80FF_FF00, grant and response immediate: `o_data_mem` = 0xFFFF_FF80 and `o_done` in cycle 2. LBU on the same data: 0x0000_0080.
- SH at address 0x202, data 0x1234_ABCD: `mem_addr` = 0x200, `mem_wstrb` = 1100, `mem_wdata` = 0xABCD_ABCD. Delay `mem_gnt` by 3 cycles: `o_stall` stays 1 and the bus outputs stay stable throughout.
- LW at address 0x006: no `mem_req` ever, `o_fault` = 1 and cause = 1 in cycle 1. `o_data_mem` keeps its previous value.
- Load with funct3 = 011: cause = 2, no bus request.
- `TIMEOUT` = 4, `mem_gnt` never asserted: `mem_req` drops and cause = 3 after 4 REQ cycles. A late `mem_rvalid` in IDLE is ignored.
- `rst` pulsed in WAIT during an LW: IDLE and all outputs 0 on the next edge. A subsequent `mem_rvalid` leaves `o_data_mem` at 0.
